ws2812_rx: RTL
==============

Name: ws2812_rx

Overview:
- Receive-side decoder for the WS2812 single-wire LED protocol, the opposite end of the harness's ws2812 transmitter.
- Samples an asynchronous data pin and classifies each bit by its high-pulse width.
- Assembles 24-bit words, tags each with its LED index within the frame, and detects the latch (reset) gap.
- Used as an on-chip loopback checker for the ws2812 project and as a chain-input front end for LED-slave experiments.

Parameters:
- THRESH_CYCLES, 6: a high pulse of this many sync'd cycles or more decodes as 1; fewer decodes as 0. At 12 MHz, T0H is about 4 cycles and T1H about 8.
- RESET_CYCLES, 600: continuous low of this length is the latch gap (50 us at 12 MHz).
- MAX_HIGH_CYCLES, 20: a high pulse longer than this is a protocol error.

Ports:
- clk  input  1  system clock, 12 MHz nominal
- reset_n  input  1  asynchronous active-low reset
- data_in  input  1  WS2812 serial line, asynchronous to clk
- rgb_data  output  24  last completed word; the first received bit is in bit 23
- led_num  output  8  index of the word in rgb_data within the current frame
- data_valid  output  1  one-cycle pulse when rgb_data/led_num update
- frame_done  output  1  one-cycle pulse at a latch gap that ends a frame of at least one word
- error  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0: rgb_data, led_num, data_valid, frame_done, error.
  - Synchronizer flops reset to 0.
  - State goes to SYNC.
- Input path:
  - data_in passes through a 2-flop synchronizer, then a 1-flop edge detector.
  - All decoding uses the synchronized signal.
- Counters:
  - hi_cnt and lo_cnt are wide enough to hold max(RESET_CYCLES, MAX_HIGH_CYCLES+1).
  - Both saturate at their limit and never wrap.
  - bit_cnt is 5 bits; idx is an 8-bit internal word counter.
- States:
  - SYNC: ignore all activity. Enter IDLE once the line has been continuously low for RESET_CYCLES. A rising edge restarts lo_cnt. No outputs are produced in this state.
  - IDLE/LOW: count lo_cnt while the line is low.
    - On a rising edge, clear hi_cnt and go to HIGH.
    - If lo_cnt reaches RESET_CYCLES, the latch gap is reached:
      - If bit_cnt is nonzero, pulse error and discard the partial word.
      - If idx is nonzero, pulse frame_done.
      - In both cases clear idx and bit_cnt, then stay in LOW, saturated with no repeat pulses, until the next rising edge.
  - HIGH: count hi_cnt.
    - If hi_cnt exceeds MAX_HIGH_CYCLES: pulse error, clear bit_cnt and idx, go to SYNC.
    - On a falling edge:
      - The bit value is (hi_cnt >= THRESH_CYCLES). Shift it into the shift register MSB-first and increment bit_cnt.
      - Clear lo_cnt and go to LOW.
      - If bit_cnt reaches 24: load rgb_data from the shift register, set led_num to idx, pulse data_valid, increment idx (wraps 255 to 0), clear bit_cnt.
- Latency:
  - Let edge E be the first clk edge that samples data_in low.
  - data_valid, for the falling edge of the 24th bit, is high in the cycle following edge E+3.
  - frame_done and error for a gap have the same 3-cycle pipeline offset.
- Hold behaviour:
  - rgb_data and led_num hold their values between data_valid pulses.
  - data_valid, frame_done and error are never high for two consecutive cycles.
- Simultaneous events:
  - A falling edge takes priority over a MAX_HIGH check in the same cycle.
  - When the latch gap is reached in the same cycle as a rising edge, the gap is processed first, then the pulse starts.
- Reset mid-word: asserting reset_n discards any partial bits. After release the block must see a full latch gap before decoding resumes.
- Glitches: a high pulse of 1 sync'd cycle decodes as 0. Deglitching beyond the synchronizer is not provided.

Test Plan:
- Reset release, then 700 low cycles, then 24 bits 0xA5C3F0 (one pulse 8 high/7 low; zero pulse 4 high/11 low), then 600 low → data_valid once with rgb_data=0xA5C3F0 and led_num=0; frame_done one pulse; error never set.
- Three back-to-back words 0xFF0000, 0x00FF00, 0x0000FF, then gap → three data_valid pulses, led_num 0/1/2 with matching rgb_data; a single frame_done; led_num of the next frame restarts at 0.
- 10 bits, then 600 low → error pulse, no data_valid, no frame_done. The next full word is decoded with led_num=0.
- Line held high for 25 cycles mid-word → error pulse; no decode until 600 low cycles have passed; then a word 0x123456 decodes correctly.
- Threshold check: high pulses of exactly 5 and exactly 6 cycles → decoded 0 and 1 respectively. Data_valid timing is checked at exactly 3 cycles after the sampled falling edge.
- reset_n asserted after bit 12, released, then a gap and word 0x00000F → outputs 0 during reset, then rgb_data=0x00000F with led_num=0.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx: receive-side decoder for the WS2812 single-wire LED protocol.
// Classifies each bit by its high-pulse width, assembles 24-bit words
// (first bit received lands in bit 23), tags each word with its index in
// the frame and reports the latch gap that ends a frame.
module ws2812_rx #(
    parameter int THRESH_CYCLES   = 6,
    parameter int RESET_CYCLES    = 600,
    parameter int MAX_HIGH_CYCLES = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_in,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        data_valid,
    output logic        frame_done,
    output logic        error
);

    // Counters must reach both the latch-gap length and one past the longest legal high pulse.
    localparam int CNT_LIM = (RESET_CYCLES > (MAX_HIGH_CYCLES + 1)) ? RESET_CYCLES : (MAX_HIGH_CYCLES + 1);
    localparam int CNT_W   = $clog2(CNT_LIM + 1);

    localparam logic [CNT_W-1:0] LO_LIM    = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(MAX_HIGH_CYCLES + 1);
    localparam logic [CNT_W-1:0] HI_MAX    = CNT_W'(MAX_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] HI_THRESH = CNT_W'(THRESH_CYCLES);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t           state_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             line_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] hi_cnt_r;
    logic [CNT_W-1:0] lo_cnt_r;
    logic [4:0]       bit_cnt_r;
    logic [7:0]       idx_r;
    logic [22:0]      shift_r;
    logic [23:0]      rgb_data_r;
    logic [7:0]       led_num_r;
    logic             data_valid_r;
    logic             frame_done_r;
    logic             error_r;

    logic [CNT_W-1:0] lo_inc_s;
    logic [CNT_W-1:0] hi_inc_s;
    logic             gap_hit_s;
    logic             bit_s;
    logic [23:0]      word_s;
    logic [4:0]       bit_cnt_inc_s;

    // Two-flop synchronizer followed by registered rise/fall pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            line_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= data_in;
            sync2_r <= sync1_r;
            line_r  <= sync2_r;
            rise_r  <= sync2_r & ~line_r;
            fall_r  <= ~sync2_r & line_r;
        end
    end

    // Saturating next-count values, gap detection and the decoded bit.
    // hi_inc_s already includes the current cycle, so it equals the pulse width on the falling edge.
    always_comb begin
        lo_inc_s      = (lo_cnt_r >= LO_LIM) ? LO_LIM : (lo_cnt_r + CNT_W'(1));
        hi_inc_s      = (hi_cnt_r >= HI_LIM) ? HI_LIM : (hi_cnt_r + CNT_W'(1));
        gap_hit_s     = (lo_inc_s == LO_LIM) && (lo_cnt_r != LO_LIM);
        bit_s         = (hi_inc_s >= HI_THRESH);
        word_s        = {shift_r, bit_s};
        bit_cnt_inc_s = bit_cnt_r + 5'd1;
    end

    // Decoder state machine with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_SYNC;
            hi_cnt_r     <= '0;
            lo_cnt_r     <= '0;
            bit_cnt_r    <= 5'd0;
            idx_r        <= 8'd0;
            shift_r      <= 23'd0;
            rgb_data_r   <= 24'd0;
            led_num_r    <= 8'd0;
            data_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            error_r      <= 1'b0;
            case (state_r)
                ST_SYNC: begin
                    // Wait for a full latch gap; entering LOW saturated suppresses a gap report.
                    bit_cnt_r <= 5'd0;
                    idx_r     <= 8'd0;
                    if (line_r) begin
                        lo_cnt_r <= '0;
                    end else begin
                        lo_cnt_r <= lo_inc_s;
                        if (lo_inc_s == LO_LIM) begin
                            state_r <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    lo_cnt_r <= lo_inc_s;
                    if (gap_hit_s) begin
                        if (bit_cnt_r != 5'd0) begin
                            error_r <= 1'b1;
                        end
                        if (idx_r != 8'd0) begin
                            frame_done_r <= 1'b1;
                        end
                        idx_r     <= 8'd0;
                        bit_cnt_r <= 5'd0;
                    end
                    if (rise_r) begin
                        hi_cnt_r <= '0;
                        state_r  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    hi_cnt_r <= hi_inc_s;
                    if (fall_r) begin
                        shift_r  <= word_s[22:0];
                        lo_cnt_r <= '0;
                        state_r  <= ST_LOW;
                        if (bit_cnt_inc_s == 5'd24) begin
                            rgb_data_r   <= word_s;
                            led_num_r    <= idx_r;
                            data_valid_r <= 1'b1;
                            idx_r        <= idx_r + 8'd1;
                            bit_cnt_r    <= 5'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_inc_s;
                        end
                    end else if (hi_inc_s > HI_MAX) begin
                        error_r   <= 1'b1;
                        bit_cnt_r <= 5'd0;
                        idx_r     <= 8'd0;
                        lo_cnt_r  <= '0;
                        state_r   <= ST_SYNC;
                    end
                end
                default: begin
                    state_r <= ST_SYNC;
                end
            endcase
        end
    end

    assign rgb_data   = rgb_data_r;
    assign led_num    = led_num_r;
    assign data_valid = data_valid_r;
    assign frame_done = frame_done_r;
    assign error      = error_r;

endmodule
